ppu_data_mem: RTL and testbench



---
 rtl/ppu_data_mem.sv | 153 +++++++++++++++
 tb/tb_ppu_data_mem.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ppu_data_mem.sv
// PPU MEM-stage data memory: big-endian byte/half/word load/store on a 2**ADDR_WIDTH byte array
// with programmable wait states. Define DMEM_ALIGN_CHECK_EN to fault misaligned accesses.
module ppu_data_mem #(
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_rw,
  input  logic [1:0]            req_size,
  input  logic                  req_se,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_fault,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state, state_nxt;
  logic [3:0]              cnt;
  logic                    accept;
  logic                    access;
  logic                    misalign;
  logic                    rw_p0, se_p0;
  logic [1:0]              size_p0;
  logic [ADDR_WIDTH-1:0]   addr_p0, addr1, addr2, addr3;
  logic [31:0]             wdata_p0;
  logic [31:0]             load_val;
  logic [7:0]              mem [DEPTH];

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic se);
    logic signed [7:0]  sb;
    logic signed [31:0] sw;
    sb = b;
    sw = 32'(sb);
    ext_byte = se ? sw : {24'd0, b};
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic se);
    logic signed [15:0] sh;
    logic signed [31:0] sw;
    sh = h;
    sw = 32'(sh);
    ext_half = se ? sw : {16'd0, h};
  endfunction

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_WAIT;
      S_WAIT:  if (cnt == 4'd0) state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    req_ready = (state == S_IDLE);
    busy      = (state != S_IDLE);
    rsp_valid = (state == S_RESP);
    access    = (state == S_WAIT) && (cnt == 4'd0);
  end

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         cnt <= 4'd0;
    else if (accept)                   cnt <= 4'(WAIT_CYCLES);
    else if (state == S_WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
  end

  // p0: request fields captured at accept, held through WAIT/RESP
  always_ff @(posedge clk) begin
    if (accept) begin
      rw_p0    <= req_rw;
      size_p0  <= req_size;
      se_p0    <= req_se;
      addr_p0  <= req_addr;
      wdata_p0 <= req_wdata;
    end
  end

  assign addr1 = addr_p0 + ADDR_WIDTH'(1);
  assign addr2 = addr_p0 + ADDR_WIDTH'(2);
  assign addr3 = addr_p0 + ADDR_WIDTH'(3);

`ifdef DMEM_ALIGN_CHECK_EN
  always_comb begin
    case (size_p0)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = addr_p0[0];
      default: misalign = (addr_p0[1:0] != 2'b00);
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    case (size_p0)
      2'b00:   load_val = ext_byte(mem[addr_p0], se_p0);
      2'b01:   load_val = ext_half({mem[addr_p0], mem[addr1]}, se_p0);
      default: load_val = {mem[addr_p0], mem[addr1], mem[addr2], mem[addr3]};
    endcase
  end

  // Stores commit only on the access edge; reset forces IDLE so a pending store never lands
  always_ff @(posedge clk) begin
    if (access && rw_p0 && !misalign) begin
      case (size_p0)
        2'b00: mem[addr_p0] <= wdata_p0[7:0];
        2'b01: begin
          mem[addr_p0] <= wdata_p0[15:8];
          mem[addr1]   <= wdata_p0[7:0];
        end
        default: begin
          mem[addr_p0] <= wdata_p0[31:24];
          mem[addr1]   <= wdata_p0[23:16];
          mem[addr2]   <= wdata_p0[15:8];
          mem[addr3]   <= wdata_p0[7:0];
        end
      endcase
    end
  end

  // p1: response registered on the access edge, held through RESP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_rdata <= 32'd0;
      rsp_fault <= 1'b0;
    end else if (access) begin
      rsp_rdata <= (rw_p0 || misalign) ? 32'd0 : load_val;
      rsp_fault <= misalign;
    end
  end

endmodule

// File: tb/tb_ppu_data_mem.sv
// Directed self-checking bench for ppu_data_mem (WAIT_CYCLES=2); expectations follow DMEM_ALIGN_CHECK_EN.
module tb_ppu_data_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_rw, req_se;
  logic [1:0]  req_size;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_fault, busy;
  logic [31:0] rsp_rdata;

  int checks   = 0;
  int failures = 0;

  logic [31:0] rd;
  logic        flt;
  int          lat;
  logic [31:0] held;

  always #5 clk = ~clk;

  ppu_data_mem #(.ADDR_WIDTH(9), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_size(req_size), .req_se(req_se), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_fault(rsp_fault), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic rw, input logic [1:0] sz, input logic se,
                       input logic [8:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_rw = rw; req_size = sz; req_se = se;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    chk("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic take(output logic [31:0] r, output logic f);
    r = rsp_rdata;
    f = rsp_fault;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic xact(input logic rw, input logic [1:0] sz, input logic se,
                      input logic [8:0] a, input logic [31:0] wd,
                      output logic [31:0] r, output logic f);
    int n;
    issue(rw, sz, se, a, wd);
    wait_rsp(n);
    take(r, f);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_size = 2'b00; req_se = 1'b0;
    req_addr = 9'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_rdata",     rsp_rdata,          32'd0);
    chk("rst_fault",     {31'd0, rsp_fault}, 32'd0);
    @(negedge clk) reset = 1'b0;

    // Store word with latency measurement
    issue(1'b1, 2'b10, 1'b0, 9'h010, 32'hDEADBEEF);
    chk("wait_busy", {31'd0, busy}, 32'd1);
    chk("wait_req_ready", {31'd0, req_ready}, 32'd0);
    wait_rsp(lat);
    chk("st_latency", lat, 32'd3);
    take(rd, flt);
    chk("st_rdata", rd, 32'd0);
    chk("st_fault", {31'd0, flt}, 32'd0);

    xact(1'b0, 2'b10, 1'b0, 9'h010, 32'd0, rd, flt);
    chk("ld_word", rd, 32'hDEADBEEF);
    xact(1'b0, 2'b00, 1'b1, 9'h010, 32'd0, rd, flt);
    chk("ld_byte_se", rd, 32'hFFFFFFDE);
    xact(1'b0, 2'b00, 1'b0, 9'h010, 32'd0, rd, flt);
    chk("ld_byte_ze", rd, 32'h000000DE);
    xact(1'b0, 2'b01, 1'b1, 9'h012, 32'd0, rd, flt);
    chk("ld_half_se", rd, 32'hFFFFBEEF);
    xact(1'b0, 2'b01, 1'b0, 9'h012, 32'd0, rd, flt);
    chk("ld_half_ze", rd, 32'h0000BEEF);
    xact(1'b0, 2'b00, 1'b1, 9'h011, 32'd0, rd, flt);
    chk("ld_byte_se_pos", rd, 32'hFFFFFFAD);
    xact(1'b0, 2'b11, 1'b1, 9'h010, 32'd0, rd, flt);
    chk("ld_reserved", rd, 32'hDEADBEEF);

    // Partial stores
    xact(1'b1, 2'b00, 1'b0, 9'h011, 32'h1111117F, rd, flt);
    xact(1'b0, 2'b10, 1'b0, 9'h010, 32'd0, rd, flt);
    chk("st_byte", rd, 32'hDE7FBEEF);
    xact(1'b1, 2'b01, 1'b0, 9'h012, 32'h55551234, rd, flt);
    xact(1'b0, 2'b10, 1'b0, 9'h010, 32'd0, rd, flt);
    chk("st_half", rd, 32'hDE7F1234);

    // Back-pressure with a competing request held high
    issue(1'b0, 2'b10, 1'b0, 9'h010, 32'd0);
    wait_rsp(lat);
    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b1; req_size = 2'b10; req_addr = 9'h010; req_wdata = 32'h0BAD0BAD;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rdata", rsp_rdata, 32'hDE7F1234);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      chk("bp_busy", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    chk("bp_release_ready", {31'd0, req_ready}, 32'd1);
    chk("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk);
    #1 chk("bp_no_accept", {31'd0, busy}, 32'd0);
    xact(1'b0, 2'b10, 1'b0, 9'h010, 32'd0, rd, flt);
    chk("bp_mem_intact", rd, 32'hDE7F1234);

    // Reset during WAIT discards a pending store
    xact(1'b1, 2'b10, 1'b0, 9'h020, 32'h11111111, rd, flt);
    issue(1'b1, 2'b10, 1'b0, 9'h020, 32'hAAAAAAAA);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_wait_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_wait_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b1; req_size = 2'b10; req_addr = 9'h020; req_wdata = 32'hBBBBBBBB;
    repeat (3) @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b0;
    #1 chk("rst_req_not_accepted", {31'd0, busy}, 32'd0);
    xact(1'b0, 2'b10, 1'b0, 9'h020, 32'd0, rd, flt);
    chk("rst_store_dropped", rd, 32'h11111111);

    // Misaligned word store wrapping the top of the array
    xact(1'b1, 2'b10, 1'b0, 9'h1FC, 32'h01020304, rd, flt);
    xact(1'b1, 2'b10, 1'b0, 9'h000, 32'h05060708, rd, flt);
    xact(1'b1, 2'b10, 1'b0, 9'h1FE, 32'hCAFEF00D, rd, flt);
    chk("mis_st_rdata", rd, 32'd0);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("mis_st_fault", {31'd0, flt}, 32'd1);
    xact(1'b0, 2'b10, 1'b0, 9'h1FC, 32'd0, rd, flt);
    chk("mis_hi_unchanged", rd, 32'h01020304);
    xact(1'b0, 2'b10, 1'b0, 9'h000, 32'd0, rd, flt);
    chk("mis_lo_unchanged", rd, 32'h05060708);
    xact(1'b0, 2'b01, 1'b0, 9'h1FF, 32'd0, rd, flt);
    chk("mis_ld_rdata", rd, 32'd0);
    chk("mis_ld_fault", {31'd0, flt}, 32'd1);
`else
    chk("mis_st_fault", {31'd0, flt}, 32'd0);
    xact(1'b0, 2'b10, 1'b0, 9'h1FC, 32'd0, rd, flt);
    chk("mis_hi_written", rd, 32'h0102CAFE);
    xact(1'b0, 2'b10, 1'b0, 9'h000, 32'd0, rd, flt);
    chk("mis_lo_written", rd, 32'hF00D0708);
    xact(1'b0, 2'b01, 1'b0, 9'h1FF, 32'd0, rd, flt);
    chk("mis_ld_rdata", rd, 32'h0000FEF0);
    chk("mis_ld_fault", {31'd0, flt}, 32'd0);
`endif
    xact(1'b0, 2'b10, 1'b0, 9'h010, 32'd0, rd, flt);
    held = rd;
    chk("aligned_fault_clear", {31'd0, flt}, 32'd0);
    chk("final_word", held, 32'hDE7F1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
